// File: rtl/execute_mc.sv
// rtl/execute_mc.sv - execute unit: single-cycle branch/jump/ALU, iterative multiply,
// restoring divide when MRISCV_DIV_EN is defined.
module execute_mc #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_branch,
    input  logic            is_jump,
    input  logic            is_reg,
    input  logic            is_alu,
    input  logic            is_muldiv,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [XLEN-1:0] branch_dest,
    input  logic [XLEN-1:0] curr_pc,
    input  logic [4:0]      dest_i,
    input  logic [2:0]      func3,
    input  logic            func7,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] next_pc,
    output logic [4:0]      dest_o
);
    localparam int SW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state, state_next;
    logic [SW-1:0]     count;
    logic              accept, last_iter, fast_op, taken, a_neg, b_neg, neg_q;
    logic [SW-1:0]     shamt;
    logic [XLEN-1:0]   pc_plus4, fast_result, fast_next_pc, mul_result;
    logic [XLEN-1:0]   mag_a_val, mag_b_val, mcand, lat_pc;
    logic [4:0]        fast_dest, lat_dest;
    logic [2:0]        lat_f3;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod, prod_step, prod_signed;
`ifdef MRISCV_DIV_EN
    logic [XLEN-1:0]   rem, quo, divisor, lat_a, rem_step, quo_step, div_q, div_r, div_result;
    logic [XLEN:0]     rem_sh, diff;
    logic              neg_r, b_zero;
`endif

    assign accept    = in_valid && in_ready;
    assign last_iter = (count == SW'(XLEN - 1));
`ifdef MRISCV_DIV_EN
    assign fast_op   = !is_muldiv;
`else
    assign fast_op   = !is_muldiv || func3[2];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            next_pc   <= '0;
            dest_o    <= '0;
            count     <= '0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= 1'b0;
            count     <= (state == MUL || state == DIV) ? count + 1'b1 : '0;
            if (accept && fast_op) begin
                out_valid <= 1'b1;
                result    <= fast_result;
                next_pc   <= fast_next_pc;
                dest_o    <= fast_dest;
            end
            if (state == MUL && last_iter) begin
                out_valid <= 1'b1;
                result    <= mul_result;
                next_pc   <= lat_pc + XLEN'(4);
                dest_o    <= lat_dest;
            end
`ifdef MRISCV_DIV_EN
            if (state == DIV && last_iter) begin
                out_valid <= 1'b1;
                result    <= div_result;
                next_pc   <= lat_pc + XLEN'(4);
                dest_o    <= lat_dest;
            end
`endif
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept && is_muldiv && !fast_op) state_next = func3[2] ? DIV : MUL;
            MUL, DIV: if (last_iter) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        pc_plus4     = curr_pc + XLEN'(4);
        shamt        = operand_b[SW-1:0];
        fast_result  = '0;
        fast_next_pc = pc_plus4;
        fast_dest    = dest_i;
        case (func3)
            3'b000:  taken = (operand_a == operand_b);
            3'b001:  taken = (operand_a != operand_b);
            3'b100:  taken = ($signed(operand_a) < $signed(operand_b));
            3'b101:  taken = ($signed(operand_a) >= $signed(operand_b));
            3'b110:  taken = (operand_a < operand_b);
            3'b111:  taken = (operand_a >= operand_b);
            default: taken = 1'b0;
        endcase
        if (is_jump) begin
            fast_result  = pc_plus4;
            fast_next_pc = is_reg ? ((operand_a + operand_b) & ~XLEN'(1)) : curr_pc + operand_a;
        end else if (is_alu) begin
            case (func3)
                3'b000:  fast_result = func7 ? operand_a - operand_b : operand_a + operand_b;
                3'b001:  fast_result = operand_a << shamt;
                3'b010:  fast_result = XLEN'($signed(operand_a) < $signed(operand_b));
                3'b011:  fast_result = XLEN'(operand_a < operand_b);
                3'b100:  fast_result = operand_a ^ operand_b;
                3'b101:  fast_result = func7 ? XLEN'($signed(operand_a) >>> shamt) : operand_a >> shamt;
                3'b110:  fast_result = operand_a | operand_b;
                default: fast_result = operand_a & operand_b;
            endcase
        end else if (is_branch) begin
            fast_dest = '0;
            if (taken) fast_next_pc = curr_pc + branch_dest;
        end else begin
            fast_dest = '0;
        end

        // Work on magnitudes; the sign is restored once the iteration finishes.
        if (func3[2]) begin
            a_neg = !func3[0] && operand_a[XLEN-1];
            b_neg = !func3[0] && operand_b[XLEN-1];
        end else begin
            a_neg = (func3 == 3'b001 || func3 == 3'b010) && operand_a[XLEN-1];
            b_neg = (func3 == 3'b001) && operand_b[XLEN-1];
        end
        mag_a_val   = a_neg ? -operand_a : operand_a;
        mag_b_val   = b_neg ? -operand_b : operand_b;

        mul_sum     = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? mcand : {XLEN{1'b0}})};
        prod_step   = {mul_sum, prod[XLEN-1:1]};
        prod_signed = neg_q ? -prod_step : prod_step;
        mul_result  = (lat_f3[1:0] == 2'b00) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
`ifdef MRISCV_DIV_EN
        rem_sh      = {rem, quo[XLEN-1]};
        diff        = rem_sh - {1'b0, divisor};
        rem_step    = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        quo_step    = {quo[XLEN-2:0], ~diff[XLEN]};
        div_q       = b_zero ? '1 : (neg_q ? -quo_step : quo_step);
        div_r       = b_zero ? lat_a : (neg_r ? -rem_step : rem_step);
        div_result  = lat_f3[1] ? div_r : div_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (accept && is_muldiv) begin
            mcand    <= mag_a_val;
            prod     <= {{XLEN{1'b0}}, mag_b_val};
            neg_q    <= a_neg ^ b_neg;
            lat_f3   <= func3;
            lat_pc   <= curr_pc;
            lat_dest <= dest_i;
`ifdef MRISCV_DIV_EN
            rem      <= '0;
            quo      <= mag_a_val;
            divisor  <= mag_b_val;
            lat_a    <= operand_a;
            neg_r    <= a_neg;
            b_zero   <= (operand_b == '0);
`endif
        end else if (state == MUL) begin
            prod     <= prod_step;
        end
`ifdef MRISCV_DIV_EN
        else if (state == DIV) begin
            rem      <= rem_step;
            quo      <= quo_step;
        end
`endif
    end
endmodule

// File: tb/tb_execute_mc.sv
// tb/tb_execute_mc.sv - scoreboard bench for execute_mc (XLEN=32), honours MRISCV_DIV_EN.
module tb_execute_mc;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid;
    logic        is_branch, is_jump, is_reg, is_alu, is_muldiv, func7;
    logic [31:0] operand_a, operand_b, branch_dest, curr_pc, result, next_pc;
    logic [4:0]  dest_i, dest_o;
    logic [2:0]  func3;

    typedef struct {
        logic [31:0] res;
        logic [31:0] npc;
        logic [4:0]  dst;
        int          cyc;
    } exp_t;

    localparam logic [4:0] BR = 5'b10000, JAL = 5'b01000, JALR = 5'b01100, ALU = 5'b00010, MD = 5'b00001;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    execute_mc #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .is_branch(is_branch), .is_jump(is_jump), .is_reg(is_reg), .is_alu(is_alu),
        .is_muldiv(is_muldiv), .operand_a(operand_a), .operand_b(operand_b),
        .branch_dest(branch_dest), .curr_pc(curr_pc), .dest_i(dest_i), .func3(func3),
        .func7(func7), .out_valid(out_valid), .result(result), .next_pc(next_pc),
        .dest_o(dest_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out_valid: got result 0x%08h, required no output", result);
            end else begin
                mon_e = sb.pop_front();
                check("result", result, mon_e.res);
                check("next_pc", next_pc, mon_e.npc);
                check("dest_o", {27'b0, dest_o}, {27'b0, mon_e.dst});
                check("latency_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic issue(input logic [4:0] cls, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] bd,
                         input logic [31:0] pc, input logic [4:0] di,
                         input logic [31:0] er, input logic [31:0] enp, input logic [4:0] ed,
                         input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        check("in_ready_at_issue", {31'b0, in_ready}, 32'd1);
        {is_branch, is_jump, is_reg, is_alu, is_muldiv} = cls;
        func3 = f3; func7 = f7; operand_a = a; operand_b = b;
        branch_dest = bd; curr_pc = pc; dest_i = di; in_valid = 1'b1;
        if (push) begin
            e.res = er; e.npc = enp; e.dst = ed; e.cyc = cyc + lat;
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle_drain();
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        check("drain", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0;
        {is_branch, is_jump, is_reg, is_alu, is_muldiv} = 5'b0;
        func3 = 3'b0; func7 = 1'b0; operand_a = '0; operand_b = '0;
        branch_dest = '0; curr_pc = '0; dest_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_next_pc", next_pc, 32'd0);
        check("reset_dest_o", {27'b0, dest_o}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        reset = 1'b0;

        // back-to-back single-cycle ops
        issue(BR,   3'b000, 0, 32'd200, 32'd200, 32'd20, 32'd20, 5'd5, 32'd0, 32'd40, 5'd0, 1, 1);
        issue(BR,   3'b100, 0, 32'd100, -32'sd300, 32'd8, 32'd40, 5'd5, 32'd0, 32'd44, 5'd0, 1, 1);
        issue(JALR, 3'b000, 0, 32'd32, 32'd17, 32'd0, 32'd4, 5'd11, 32'd8, 32'd48, 5'd11, 1, 1);
        issue(ALU,  3'b101, 1, 32'hF9936F04, 32'h99FF0098, 32'd0, 32'h200, 5'd3, 32'hFFFFFFF9, 32'h204, 5'd3, 1, 1);
        issue(JAL,  3'b000, 0, 32'h100, 32'd0, 32'd0, 32'hFFFFFF00, 5'd1, 32'hFFFFFF04, 32'h0, 5'd1, 1, 1);
        issue(ALU,  3'b000, 1, 32'd5, 32'd7, 32'd0, 32'h10, 5'd2, 32'hFFFFFFFE, 32'h14, 5'd2, 1, 1);
        issue(ALU,  3'b011, 0, 32'd1, 32'hFFFFFFFF, 32'd0, 32'h20, 5'd4, 32'd1, 32'h24, 5'd4, 1, 1);
        issue(ALU,  3'b010, 0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h30, 5'd6, 32'd1, 32'h34, 5'd6, 1, 1);
        issue(ALU,  3'b001, 0, 32'd1, 32'd33, 32'd0, 32'h40, 5'd8, 32'd2, 32'h44, 5'd8, 1, 1);
        issue(BR,   3'b111, 0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 32'h80, 5'd9, 32'd0, 32'h70, 5'd0, 1, 1);
        idle_drain();

        // mulh with inputs scrambled while busy
        issue(MD, 3'b001, 0, -32'sd3, 32'h40000000, 32'd0, 32'h100, 5'd7, 32'hFFFFFFFF, 32'h104, 5'd7, 33, 1);
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            check("in_ready_busy", {31'b0, in_ready}, 32'd0);
            operand_a = $urandom; operand_b = $urandom; curr_pc = $urandom;
            dest_i = 5'($urandom_range(0, 31)); func3 = 3'($urandom_range(0, 7));
            if (i == 32) in_valid = 1'b0;
        end
        @(negedge clk);
        check("in_ready_after_mul", {31'b0, in_ready}, 32'd1);
        idle_drain();

        issue(MD, 3'b000, 0, 32'h12345678, 32'h10, 32'd0, 32'h200, 5'd12, 32'h23456780, 32'h204, 5'd12, 33, 1);
        idle_drain();
        issue(MD, 3'b011, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h210, 5'd13, 32'hFFFFFFFE, 32'h214, 5'd13, 33, 1);
        idle_drain();
        issue(MD, 3'b010, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h220, 5'd14, 32'hFFFFFFFF, 32'h224, 5'd14, 33, 1);
        idle_drain();

`ifdef MRISCV_DIV_EN
        issue(MD, 3'b100, 0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h300, 5'd15, 32'h80000000, 32'h304, 5'd15, 33, 1);
        idle_drain();
        issue(MD, 3'b101, 0, 32'd5, 32'd0, 32'd0, 32'h310, 5'd16, 32'hFFFFFFFF, 32'h314, 5'd16, 33, 1);
        idle_drain();
        issue(MD, 3'b110, 0, -32'sd7, 32'd2, 32'd0, 32'h320, 5'd17, 32'hFFFFFFFF, 32'h324, 5'd17, 33, 1);
        idle_drain();
        issue(MD, 3'b111, 0, 32'd5, 32'd0, 32'd0, 32'h330, 5'd18, 32'd5, 32'h334, 5'd18, 33, 1);
        idle_drain();
        issue(MD, 3'b100, 0, -32'sd7, 32'd2, 32'd0, 32'h340, 5'd19, 32'hFFFFFFFD, 32'h344, 5'd19, 33, 1);
        idle_drain();
`else
        issue(MD, 3'b100, 0, -32'sd7, 32'd2, 32'd0, 32'h300, 5'd15, 32'd0, 32'h304, 5'd0, 1, 1);
        idle_drain();
`endif

        // reset aborts an in-flight multiply: nothing is expected from it
        issue(MD, 3'b000, 0, 32'd3, 32'd5, 32'd0, 32'h400, 5'd9, 32'd0, 32'd0, 5'd0, 33, 0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("in_ready_after_abort", {31'b0, in_ready}, 32'd1);
        check("out_valid_after_abort", {31'b0, out_valid}, 32'd0);
        repeat (40) @(negedge clk);
        issue(ALU, 3'b000, 0, 32'd100, -32'sd200, 32'd0, 32'h500, 5'd20, 32'hFFFFFF9C, 32'h504, 5'd20, 1, 1);
        idle_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
